render_scheduler: RTL and testbench
===================================

// Module: render_scheduler
// PURPOSE
// Frame-level sequencer for the render datapath. On frame_start_in it snapshots up to MAX_OBJS objects
// from object storage into a shadow buffer, so physics may overwrite storage mid-frame, then sweeps every
// pixel. Each pixel is issued as two render beats (objects 0-3, then objects 4-7). It drains the render
// pipeline and gates framebuffer writes so exactly one write is made per pixel.
// PARAMETERS
// H_ACTIVE     1280  hcount sweep limit (exclusive)
// V_ACTIVE     720   vcount sweep limit (exclusive)
// PIX_STEP     2     hcount/vcount increment (render halves coordinates)
// MAX_OBJS     8     shadow buffer depth; must be 8 (two beats of 4)
// RD_LATENCY   2     object-storage read latency, cycles
// PIXELS       (H_ACTIVE/PIX_STEP)*(V_ACTIVE/PIX_STEP) = 230400, expected render valid_out pulses
// PORTS
// clk_in          in   1      system clock
// rst_in          in   1      synchronous active-high reset
// frame_start_in  in   1      pulse: begin a frame; ignored unless IDLE
// obj_count_in    in   4      live objects 0..8, sampled with frame_start_in
// fb_ready_in     in   1      framebuffer can accept; low stalls sweep and drain
// obj_addr_out    out  3      object-storage read address
// obj_data_in     in   83     {is_static[82], id[81:80], params[79:32], pos_x[31:16], pos_y[15:0]}
// rnd_rst_out     out  1      one-cycle render reset (realigns render set parity)
// rnd_valid_out   out  1      render valid_in beat
// rnd_is_static   out  4      per-slot static bits for current beat
// rnd_id_bits     out  4x2    per-slot id; 2'b00 = empty slot
// rnd_params      out  4x48   per-slot params
// rnd_pos_x/_y    out  4x16   per-slot position
// rnd_hcount      out  11     pixel h coordinate of current beat
// rnd_vcount      out  10     pixel v coordinate of current beat
// rnd_valid_in    in   1      render valid_out
// fb_we_out       out  1      framebuffer write enable = rnd_valid_in && (wr_count < PIXELS)
// busy_out        out  1      high in every state except IDLE
// done_out        out  1      one-cycle pulse when the frame completes
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; shadow entries id=00; counters 0. Reset mid-frame aborts with no done.
// - FSM: IDLE -> FETCH (on frame_start_in; latch obj_count, assert rnd_rst_out 1 cycle) -> SWEEP -> DRAIN
//   -> DONE (1 cycle, done_out=1) -> IDLE.
// - FETCH: drive addr 0..7 on consecutive cycles; capture obj_data_in RD_LATENCY cycles after each address.
//   Slots with index >= obj_count are forced to id=00. Exit after slot 7 is captured (8+RD_LATENCY cycles).
// - SWEEP: beats are issued as pairs. Beat A presents slots 0-3; beat B presents slots 4-7 with the same
//   h/v coordinates. rnd_valid_out=1 on a beat only when fb_ready_in=1; otherwise hold all outputs and do
//   not advance. A pair is never split by advancement: a stall between A and B re-presents B.
// - Raster: h += PIX_STEP after beat B; at h=H_ACTIVE-PIX_STEP, wrap h=0 and v += PIX_STEP. After the
//   pair at (H_ACTIVE-2, V_ACTIVE-2) -> DRAIN.
// - DRAIN: issue dummy pairs (all ids 00, h=v=0), same stall rules, until wr_count == PIXELS.
// - wr_count (18b) increments on each rnd_valid_in while < PIXELS; further pulses are ignored (no write).
// - frame_start_in while busy is ignored. obj_count_in > 8 is treated as 8.
// - Storage changes after FETCH have no effect on the current frame.
// STRUCTURE
// - render_pkg: obj_word_t struct (83b layout above), ID_NONE/CIRCLE/LINE/RECT = 2'b00..11, sched_state_t enum.
// - Sub-module: obj_shadow_buf (8x83 register file, write port from FETCH, two 4-slot read views).
// - Raster h/v counters and pair-phase bit live inline in render_scheduler.
// TESTING
// - obj_count=3 (circle, line, rect), fb_ready=1 -> slots 3-7 id=00; exactly 230400 fb_we_out; done 1 pulse.
// - obj_count=0 -> every beat has ids 00; 230400 writes; done_out asserted; busy falls the cycle after done.
// - fb_ready toggling 1/0 every 3 cycles -> no dropped/duplicated pair; beat B coords == beat A coords;
//   write count still 230400.
// - Overwrite storage slot 0 during SWEEP -> rnd_params[0] unchanged until the next frame.
// - rst_in mid-SWEEP at v=100 -> next cycle IDLE, outputs 0, no done_out; a new frame_start completes normally.
// - frame_start_in pulsed during SWEEP -> ignored; a single done_out per accepted start.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types for the render frame sequencer: object word layout, object ids, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package render_pkg;

  localparam int H_ACTIVE_DEF   = 1280;
  localparam int V_ACTIVE_DEF   = 720;
  localparam int PIX_STEP_DEF   = 2;
  localparam int RD_LATENCY_DEF = 2;
  localparam int MAX_OBJS       = 8;
  localparam int SLOTS_PER_BEAT = 4;

  localparam logic [1:0] ID_NONE   = 2'b00;
  localparam logic [1:0] ID_CIRCLE = 2'b01;
  localparam logic [1:0] ID_LINE   = 2'b10;
  localparam logic [1:0] ID_RECT   = 2'b11;

  // 83-bit object-storage word: {is_static, id, params, pos_x, pos_y}
  typedef struct packed {
    logic        is_static;
    logic [1:0]  id;
    logic [47:0] params;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
  } obj_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  // More than MAX_OBJS live objects cannot fit the shadow buffer; saturate.
  function automatic logic [3:0] clamp_count(input logic [3:0] cnt);
    return (cnt > 4'(MAX_OBJS)) ? 4'(MAX_OBJS) : cnt;
  endfunction

endpackage

// File: rtl/obj_shadow_buf.sv
// Shadow copy of the 8 object words taken at frame start, read as two 4-slot views.
// Latency: write lands on the next clock; read views are combinational from registers.
// Backpressure: none; written only during FETCH.
// Ports: clk_i/rst_i (sync active-high), wr_en_i/wr_addr_i/wr_dat_i write port,
//        view_lo_o = slots 0-3, view_hi_o = slots 4-7.
module obj_shadow_buf
  import render_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_en_i,
  input  logic [2:0]                     wr_addr_i,
  input  obj_word_t                      wr_dat_i,
  output obj_word_t [SLOTS_PER_BEAT-1:0] view_lo_o,
  output obj_word_t [SLOTS_PER_BEAT-1:0] view_hi_o
);

  obj_word_t [MAX_OBJS-1:0] mem_q;

  // Reset clears every entry, which leaves all ids at ID_NONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign view_lo_o = mem_q[3:0];
  assign view_hi_o = mem_q[7:4];

endmodule

// File: rtl/render_scheduler.sv
// Frame sequencer: snapshot objects, sweep pixels as A/B beat pairs, drain render, gate FB writes.
// Latency: 8+RD_LATENCY fetch cycles, then 2 beats per pixel; render beats are combinational from state.
// Backpressure: fb_ready_in low holds all render outputs and stalls sweep and drain in place.
// Ports: clk_in/rst_in, frame_start_in/obj_count_in, obj_addr_out/obj_data_in (storage read),
//        rnd_* render beat interface, rnd_valid_in/fb_we_out write gating, busy_out/done_out status.
module render_scheduler
  import render_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int PIX_STEP   = PIX_STEP_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_start_in,
  input  logic [3:0]       obj_count_in,
  input  logic             fb_ready_in,
  output logic [2:0]       obj_addr_out,
  input  logic [82:0]      obj_data_in,
  output logic             rnd_rst_out,
  output logic             rnd_valid_out,
  output logic [3:0]       rnd_is_static,
  output logic [3:0][1:0]  rnd_id_bits,
  output logic [3:0][47:0] rnd_params,
  output logic [3:0][15:0] rnd_pos_x,
  output logic [3:0][15:0] rnd_pos_y,
  output logic [10:0]      rnd_hcount,
  output logic [9:0]       rnd_vcount,
  input  logic             rnd_valid_in,
  output logic             fb_we_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int          PIXELS     = (H_ACTIVE / PIX_STEP) * (V_ACTIVE / PIX_STEP);
  localparam logic [17:0] PIXELS_W   = 18'(PIXELS);
  localparam logic [3:0]  FETCH_LAST = 4'(MAX_OBJS + RD_LATENCY - 1);
  localparam logic [3:0]  RD_LAT_W   = 4'(RD_LATENCY);
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE - PIX_STEP);
  localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE - PIX_STEP);
  localparam logic [10:0] H_STEP     = 11'(PIX_STEP);
  localparam logic [9:0]  V_STEP     = 10'(PIX_STEP);

  sched_state_t state_q, state_d;
  logic [3:0]   count_q, count_d;
  logic [3:0]   fcnt_q, fcnt_d;
  logic [10:0]  h_q, h_d;
  logic [9:0]   v_q, v_d;
  logic         phase_q, phase_d;      // 0 = beat A (slots 0-3), 1 = beat B (slots 4-7)
  logic [17:0]  wr_q, wr_d;
  logic         rst_pulse_q, rst_pulse_d;

  logic                           cap_en;
  logic [3:0]                     cap_idx;
  obj_word_t                      cap_word;
  obj_word_t [SLOTS_PER_BEAT-1:0] view_lo, view_hi, view_sel;
  logic                           wr_open;
  logic                           drain_exit;

  assign busy_out   = (state_q != ST_IDLE);
  assign done_out   = (state_q == ST_DONE);
  assign rnd_rst_out = rst_pulse_q;
  assign wr_open    = (wr_q < PIXELS_W);
  // Writes past PIXELS come from dummy drain pairs and must not reach the framebuffer.
  assign fb_we_out  = rnd_valid_in && busy_out && wr_open;
  // Leave DRAIN only on a pair boundary so a dummy pair is never cut in half.
  assign drain_exit = !phase_q && !wr_open;

  // Storage data for address a arrives RD_LATENCY cycles after a was driven.
  assign cap_en  = (state_q == ST_FETCH) && (fcnt_q >= RD_LAT_W);
  assign cap_idx = fcnt_q - RD_LAT_W;
  assign obj_addr_out = ((state_q == ST_FETCH) && (fcnt_q < 4'(MAX_OBJS))) ? fcnt_q[2:0] : 3'd0;

  always_comb begin
    cap_word = obj_word_t'(obj_data_in);
    if (cap_idx >= count_q) cap_word.id = ID_NONE;
  end

  obj_shadow_buf u_shadow (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .wr_en_i   (cap_en),
    .wr_addr_i (cap_idx[2:0]),
    .wr_dat_i  (cap_word),
    .view_lo_o (view_lo),
    .view_hi_o (view_hi)
  );

  assign view_sel = phase_q ? view_hi : view_lo;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      fcnt_q      <= '0;
      h_q         <= '0;
      v_q         <= '0;
      phase_q     <= 1'b0;
      wr_q        <= '0;
      rst_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      fcnt_q      <= fcnt_d;
      h_q         <= h_d;
      v_q         <= v_d;
      phase_q     <= phase_d;
      wr_q        <= wr_d;
      rst_pulse_q <= rst_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    fcnt_d      = fcnt_q;
    h_d         = h_q;
    v_d         = v_q;
    phase_d     = phase_q;
    wr_d        = wr_q;
    rst_pulse_d = 1'b0;
    if (fb_we_out) wr_d = wr_q + 18'd1;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start_in) begin
          state_d     = ST_FETCH;
          count_d     = clamp_count(obj_count_in);
          fcnt_d      = '0;
          h_d         = '0;
          v_d         = '0;
          phase_d     = 1'b0;
          wr_d        = '0;
          rst_pulse_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (fcnt_q == FETCH_LAST) state_d = ST_SWEEP;
        else                      fcnt_d  = fcnt_q + 4'd1;
      end
      ST_SWEEP: begin
        if (fb_ready_in) begin
          phase_d = ~phase_q;
          // Raster advances only once beat B of the pair has been accepted.
          if (phase_q) begin
            if (h_q == H_LAST) begin
              h_d = '0;
              if (v_q == V_LAST) begin
                v_d     = '0;
                state_d = ST_DRAIN;
              end else begin
                v_d = v_q + V_STEP;
              end
            end else begin
              h_d = h_q + H_STEP;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (drain_exit)       state_d = ST_DONE;
        else if (fb_ready_in) phase_d = ~phase_q;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Drain pairs are all-zero dummies; only SWEEP presents real slots and coordinates.
  always_comb begin
    rnd_valid_out = 1'b0;
    rnd_is_static = '0;
    rnd_id_bits   = '0;
    rnd_params    = '0;
    rnd_pos_x     = '0;
    rnd_pos_y     = '0;
    rnd_hcount    = '0;
    rnd_vcount    = '0;
    case (state_q)
      ST_SWEEP: begin
        rnd_valid_out = fb_ready_in;
        rnd_hcount    = h_q;
        rnd_vcount    = v_q;
        for (int s = 0; s < SLOTS_PER_BEAT; s++) begin
          rnd_is_static[s] = view_sel[s].is_static;
          rnd_id_bits[s]   = view_sel[s].id;
          rnd_params[s]    = view_sel[s].params;
          rnd_pos_x[s]     = view_sel[s].pos_x;
          rnd_pos_y[s]     = view_sel[s].pos_y;
        end
      end
      ST_DRAIN: rnd_valid_out = fb_ready_in && !drain_exit;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_render_scheduler.sv
// Scoreboard bench for render_scheduler on a reduced raster (16x12, step 2 -> 48 pixels).
// A frame-level model snapshots storage at frame start and queues every expected beat;
// a negedge monitor pops and compares each presented beat and models the render pipeline.
module tb_render_scheduler;
  import render_pkg::*;

  localparam int H       = 16;
  localparam int V       = 12;
  localparam int STEP    = 2;
  localparam int RDL     = 2;
  localparam int PIX     = (H / STEP) * (V / STEP);
  localparam int TIMEOUT = 4000;
  localparam int RND_DEPTH = 2;   // render holds this many pairs before producing a pixel

  logic             clk;
  logic             rst_in;
  logic             frame_start_in;
  logic [3:0]       obj_count_in;
  logic             fb_ready_in;
  logic [2:0]       obj_addr_out;
  logic [82:0]      obj_data_in;
  logic             rnd_rst_out;
  logic             rnd_valid_out;
  logic [3:0]       rnd_is_static;
  logic [3:0][1:0]  rnd_id_bits;
  logic [3:0][47:0] rnd_params;
  logic [3:0][15:0] rnd_pos_x;
  logic [3:0][15:0] rnd_pos_y;
  logic [10:0]      rnd_hcount;
  logic [9:0]       rnd_vcount;
  logic             rnd_valid_in;
  logic             fb_we_out;
  logic             busy_out;
  logic             done_out;

  render_scheduler #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PIX_STEP(STEP), .RD_LATENCY(RDL)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .obj_count_in   (obj_count_in),
    .fb_ready_in    (fb_ready_in),
    .obj_addr_out   (obj_addr_out),
    .obj_data_in    (obj_data_in),
    .rnd_rst_out    (rnd_rst_out),
    .rnd_valid_out  (rnd_valid_out),
    .rnd_is_static  (rnd_is_static),
    .rnd_id_bits    (rnd_id_bits),
    .rnd_params     (rnd_params),
    .rnd_pos_x      (rnd_pos_x),
    .rnd_pos_y      (rnd_pos_y),
    .rnd_hcount     (rnd_hcount),
    .rnd_vcount     (rnd_vcount),
    .rnd_valid_in   (rnd_valid_in),
    .fb_we_out      (fb_we_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [10:0]  h;
    logic [9:0]   v;
    logic [3:0]   st;
    logic [7:0]   id;
    logic [191:0] par;
    logic [63:0]  px;
    logic [63:0]  py;
  } beat_t;

  beat_t     exp_q[$];
  obj_word_t mem [8];
  obj_word_t snap [8];
  obj_word_t rd1;

  int checks = 0;
  int errors = 0;
  int beats_seen = 0, we_cnt = 0, done_cnt = 0, rstp_cnt = 0, last_v = -1;
  int fire_req = 0, fire_ack = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Object storage with a two-cycle read.
  always @(posedge clk) begin
    rd1         <= mem[obj_addr_out];
    obj_data_in <= rd1;
  end

  function automatic beat_t mk_beat(input int base, input int h, input int v);
    beat_t b;
    b.h = 11'(h); b.v = 10'(v);
    b.st = '0; b.id = '0; b.par = '0; b.px = '0; b.py = '0;
    for (int s = 0; s < 4; s++) begin
      b.st[s]          = snap[base+s].is_static;
      b.id[2*s +: 2]   = snap[base+s].id;
      b.par[48*s +: 48] = snap[base+s].params;
      b.px[16*s +: 16] = snap[base+s].pos_x;
      b.py[16*s +: 16] = snap[base+s].pos_y;
    end
    return b;
  endfunction

  // Input driver: render valid pulses and fb_ready pattern, changed just after the active edge.
  initial begin
    int cyc;
    cyc = 0;
    rnd_valid_in = 1'b0;
    fb_ready_in  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (fire_req != fire_ack) begin
        rnd_valid_in = 1'b1;
        fire_ack++;
      end else begin
        rnd_valid_in = 1'b0;
      end
      cyc++;
      case (rdy_mode)
        0:       fb_ready_in = 1'b1;
        1:       fb_ready_in = ((cyc / 3) % 2) == 0;
        default: fb_ready_in = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compares beats against the queue and models the render pipeline.
  initial begin
    beat_t e;
    int    pend;
    bit    b_par, done_prev;
    pend = 0; b_par = 0; done_prev = 0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        pend = 0; b_par = 0; done_prev = 0;
      end else begin
        if (rnd_rst_out) begin
          pend = 0; b_par = 0; rstp_cnt++;
        end
        if (rnd_valid_out) begin
          beats_seen++;
          last_v = int'(rnd_vcount);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_hv",     256'({rnd_hcount, rnd_vcount}), 256'({e.h, e.v}));
            chk("beat_id",     256'(rnd_id_bits),   256'(e.id));
            chk("beat_static", 256'(rnd_is_static), 256'(e.st));
            chk("beat_params", 256'(rnd_params),    256'(e.par));
            chk("beat_pos",    256'({rnd_pos_x, rnd_pos_y}), 256'({e.px, e.py}));
          end else begin
            chk("drain_id", 256'(rnd_id_bits), 256'(0));
            chk("drain_hv", 256'({rnd_hcount, rnd_vcount}), 256'(0));
          end
          if (b_par) begin
            pend++;
            if (pend > RND_DEPTH) begin
              pend--;
              fire_req++;
            end
          end
          b_par = !b_par;
        end
        if (fb_we_out) we_cnt++;
        if (done_prev) chk("busy_after_done", 256'(busy_out), 256'(0));
        if (done_out) done_cnt++;
        done_prev = done_out;
      end
    end
  end

  task automatic run_frame(input int cnt, input int mode, input bit ovw, input bit spur, input int abort_v);
    int  eff, b0, w0, d0, r0, t;
    bit  ovw_done, spur_done;
    ovw_done = 0; spur_done = 0;
    rdy_mode = mode;
    for (int s = 0; s < 8; s++) begin
      mem[s].is_static = 1'($urandom);
      mem[s].id        = 2'(s % 3 + 1);   // circle, line, rect, circle, ...
      mem[s].params    = 48'({$urandom, $urandom});
      mem[s].pos_x     = 16'($urandom);
      mem[s].pos_y     = 16'($urandom);
    end
    eff = (cnt > 8) ? 8 : cnt;
    for (int s = 0; s < 8; s++) begin
      snap[s] = mem[s];
      if (s >= eff) snap[s].id = ID_NONE;
    end
    for (int v = 0; v < V; v += STEP)
      for (int h = 0; h < H; h += STEP) begin
        exp_q.push_back(mk_beat(0, h, v));
        exp_q.push_back(mk_beat(4, h, v));
      end
    b0 = beats_seen; w0 = we_cnt; d0 = done_cnt; r0 = rstp_cnt;
    @(posedge clk); #1;
    obj_count_in   = 4'(cnt);
    frame_start_in = 1'b1;
    @(posedge clk); #1;
    frame_start_in = 1'b0;
    obj_count_in   = 4'($urandom);
    for (t = 0; t < TIMEOUT; t++) begin
      if (done_cnt != d0) break;
      frame_start_in = 1'b0;
      if (ovw && !ovw_done && (beats_seen - b0) >= 10) begin
        mem[0].params = ~mem[0].params;
        mem[0].pos_x  = ~mem[0].pos_x;
        ovw_done = 1;
      end
      if (spur && !spur_done && (beats_seen - b0) >= 20) begin
        frame_start_in = 1'b1;
        spur_done = 1;
      end
      if (abort_v >= 0 && (beats_seen - b0) > 0 && last_v == abort_v) begin
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_busy",  256'(busy_out),      256'(0));
        chk("abort_done",  256'(done_out),      256'(0));
        chk("abort_valid", 256'(rnd_valid_out), 256'(0));
        chk("abort_rrst",  256'(rnd_rst_out),   256'(0));
        chk("abort_addr",  256'(obj_addr_out),  256'(0));
        chk("abort_fbwe",  256'(fb_we_out),     256'(0));
        chk("abort_hv",    256'({rnd_hcount, rnd_vcount}), 256'(0));
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 256'(done_cnt - d0), 256'(0));
        return;
      end
      @(posedge clk); #1;
    end
    frame_start_in = 1'b0;
    chk("frame_done", 256'(done_cnt - d0), 256'(1));
    repeat (6) @(posedge clk);
    #1;
    chk("done_pulses",    256'(done_cnt - d0),  256'(1));
    chk("fb_writes",      256'(we_cnt - w0),    256'(PIX));
    chk("rnd_rst_pulses", 256'(rstp_cnt - r0),  256'(1));
    chk("beats_left",     256'(exp_q.size()),   256'(0));
    chk("idle_busy",      256'(busy_out),       256'(0));
  endtask

  initial begin
    rst_in         = 1'b1;
    frame_start_in = 1'b0;
    obj_count_in   = '0;
    for (int s = 0; s < 8; s++) mem[s] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  256'(busy_out),      256'(0));
    chk("rst_done",  256'(done_out),      256'(0));
    chk("rst_valid", 256'(rnd_valid_out), 256'(0));
    chk("rst_rrst",  256'(rnd_rst_out),   256'(0));
    chk("rst_addr",  256'(obj_addr_out),  256'(0));
    chk("rst_fbwe",  256'(fb_we_out),     256'(0));
    chk("rst_hv",    256'({rnd_hcount, rnd_vcount}), 256'(0));
    chk("rst_ids",   256'(rnd_id_bits),   256'(0));
    @(posedge clk); #1;
    rst_in = 1'b0;

    run_frame(3,  0, 0, 0, -1);   // three objects, always ready
    run_frame(0,  0, 0, 0, -1);   // no objects
    run_frame(8,  1, 0, 0, -1);   // ready toggles every 3 cycles
    run_frame(5,  2, 1, 1, -1);   // storage overwrite and spurious start mid-sweep
    run_frame(12, 2, 0, 0, -1);   // count above 8 saturates
    run_frame(6,  1, 0, 0, 6);    // reset mid-sweep
    run_frame(8,  0, 0, 0, -1);   // clean frame after abort

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
